// File: rtl/mac_conv_ctrl_if.sv
// Bundle of the load stream, result stream and MAC operand/result signals
// seen by the convolution sequencer.
interface mac_conv_ctrl_if;
    // Both streams use valid/ready: a word moves on a cycle where valid and ready
    // are both high at the rising edge, and the sender holds valid and data
    // stable until that happens.
    logic [13:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [27:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        mac_reset;
    logic [13:0] mac_a;
    logic [13:0] mac_b;
    logic        mac_valid_in;
    logic [27:0] mac_f;
    logic        mac_valid_out;

    modport master (
        input  s_data, s_valid, m_ready, mac_f, mac_valid_out,
        output s_ready, m_data, m_valid, mac_reset, mac_a, mac_b, mac_valid_in
    );

    modport slave (
        output s_data, s_valid, m_ready, mac_f, mac_valid_out,
        input  s_ready, m_data, m_valid, mac_reset, mac_a, mac_b, mac_valid_in
    );
endinterface

// File: rtl/mac_conv_ctrl.sv
// Valid-mode 1-D convolution sequencer: loads M taps and N samples, then runs
// N-M+1 dot products through one shared pipelined MAC and streams the results.
module mac_conv_ctrl #(
    parameter int M    = 4,
    parameter int N    = 8,
    parameter int PIPE = 5
) (
    input  logic            clk,
    input  logic            reset,
    mac_conv_ctrl_if.master bus,
    output logic [2:0]      dbg_state,
    output logic            dbg_late
);
    localparam int WW  = $clog2(M);
    localparam int XW  = $clog2(N);
    localparam int SW  = $clog2(M + 1);
    localparam int LAT = 1 + M + PIPE;
    localparam int CW  = $clog2(LAT + 2);

    localparam logic [WW-1:0] W_LAST    = WW'(M - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(N - 1);
    localparam logic [XW-1:0] K_LAST    = XW'(N - M);
    localparam logic [SW-1:0] SEEN_LAST = SW'(M - 1);
    localparam logic [SW-1:0] SEEN_DONE = SW'(M);

    typedef enum logic [2:0] {
        LOAD_W = 3'd0,
        LOAD_X = 3'd1,
        CLEAR  = 3'd2,
        ISSUE  = 3'd3,
        DRAIN  = 3'd4,
        OUTPUT = 3'd5
    } state_t;

    state_t        state, state_nx;
    logic [13:0]   w [M];
    logic [13:0]   x [N];
    logic [WW-1:0] wi, j;
    logic [XW-1:0] xi, k, idx;
    logic [SW-1:0] seen;
    logic [CW-1:0] cyc;
    logic [27:0]   m_data_q;
    logic          s_rdy, m_vld, vin, s_fire, pulse, done;
    logic [13:0]   op_a, op_b;

    always_comb begin
        state_nx = state;
        s_rdy    = 1'b0;
        m_vld    = 1'b0;
        vin      = 1'b0;
        op_a     = '0;
        op_b     = '0;
        idx      = k + XW'(j);
        pulse    = bus.mac_valid_out && (state == ISSUE || state == DRAIN);
        done     = (state == DRAIN) &&
                   ((pulse && seen == SEEN_LAST) || seen == SEEN_DONE);
        s_fire   = 1'b0;
        case (state)
            LOAD_W: begin
                s_rdy  = !reset;
                s_fire = bus.s_valid && s_rdy;
                if (s_fire && wi == W_LAST) state_nx = LOAD_X;
            end
            LOAD_X: begin
                s_rdy  = !reset;
                s_fire = bus.s_valid && s_rdy;
                if (s_fire && xi == X_LAST) state_nx = CLEAR;
            end
            CLEAR:  state_nx = ISSUE;
            ISSUE: begin
                vin  = 1'b1;
                op_a = w[j];
                op_b = x[idx];
                if (j == W_LAST) state_nx = DRAIN;
            end
            DRAIN:  if (done) state_nx = OUTPUT;
            OUTPUT: begin
                m_vld = 1'b1;
                if (bus.m_ready) state_nx = (k == K_LAST) ? LOAD_W : CLEAR;
            end
            default: state_nx = LOAD_W;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD_W;
            wi       <= '0;
            xi       <= '0;
            k        <= '0;
            j        <= '0;
            seen     <= '0;
            cyc      <= '0;
            m_data_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                LOAD_W: if (s_fire) begin
                    w[wi] <= bus.s_data;
                    wi    <= (wi == W_LAST) ? '0 : wi + WW'(1);
                end
                LOAD_X: if (s_fire) begin
                    x[xi] <= bus.s_data;
                    xi    <= (xi == X_LAST) ? '0 : xi + XW'(1);
                    if (xi == X_LAST) k <= '0;
                end
                CLEAR: begin
                    j    <= '0;
                    seen <= '0;
                    cyc  <= CW'(1);
                end
                ISSUE, DRAIN: begin
                    if (state == ISSUE) j <= j + WW'(1);
                    if (pulse) seen <= seen + SW'(1);
                    if (done) m_data_q <= bus.mac_f;
                    if (cyc != {CW{1'b1}}) cyc <= cyc + CW'(1);
                end
                OUTPUT: if (bus.m_ready) begin
                    // A new frame always starts with fresh taps.
                    if (k == K_LAST) begin
                        wi <= '0;
                        xi <= '0;
                    end else begin
                        k <= k + XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready      = s_rdy;
    assign bus.m_valid      = m_vld;
    assign bus.m_data       = m_data_q;
    assign bus.mac_reset    = reset || (state == CLEAR);
    assign bus.mac_a        = op_a;
    assign bus.mac_b        = op_b;
    assign bus.mac_valid_in = vin;
    assign dbg_state        = state;
    // Flags a dot product that has waited past its nominal MAC latency.
    assign dbg_late         = (state == DRAIN) && (cyc > CW'(LAT));
endmodule

// File: tb/tb_mac_conv_ctrl.sv
// Directed bench for mac_conv_ctrl with a behavioural pipelined MAC and an
// expected-result scoreboard per DUT.
module tb_mac_conv_ctrl;
    localparam int PIPE = 5;

    logic clk;
    logic reset;
    logic [2:0] st_a, st_b;
    logic late_a, late_b;

    mac_conv_ctrl_if bus_a ();
    mac_conv_ctrl_if bus_b ();

    mac_conv_ctrl #(.M(4), .N(8), .PIPE(PIPE)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.master),
        .dbg_state(st_a), .dbg_late(late_a)
    );
    mac_conv_ctrl #(.M(4), .N(4), .PIPE(PIPE)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.master),
        .dbg_state(st_b), .dbg_late(late_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural MAC: PIPE-cycle product pipeline into a wrapping 28-bit accumulator
    for (genvar g = 0; g < 2; g++) begin : mac_model
        logic [13:0] a, b;
        logic        vin, rst;
        logic        pv [PIPE];
        logic [27:0] pp [PIPE];
        logic [27:0] acc, f;
        assign rst = (g == 0) ? bus_a.mac_reset    : bus_b.mac_reset;
        assign vin = (g == 0) ? bus_a.mac_valid_in : bus_b.mac_valid_in;
        assign a   = (g == 0) ? bus_a.mac_a        : bus_b.mac_a;
        assign b   = (g == 0) ? bus_a.mac_b        : bus_b.mac_b;
        assign f   = acc + (pv[PIPE-1] ? pp[PIPE-1] : 28'd0);
        always @(posedge clk) begin
            if (rst) begin
                acc <= '0;
                for (int i = 0; i < PIPE; i++) begin
                    pv[i] <= 1'b0;
                    pp[i] <= '0;
                end
            end else begin
                acc   <= f;
                pv[0] <= vin;
                pp[0] <= $signed({{14{a[13]}}, a}) * $signed({{14{b[13]}}, b});
                for (int i = 1; i < PIPE; i++) begin
                    pv[i] <= pv[i-1];
                    pp[i] <= pp[i-1];
                end
            end
        end
        if (g == 0) begin : conn_a
            assign bus_a.mac_f         = f;
            assign bus_a.mac_valid_out = pv[PIPE-1];
        end else begin : conn_b
            assign bus_b.mac_f         = f;
            assign bus_b.mac_valid_out = pv[PIPE-1];
        end
    end

    // scoreboard
    int checks = 0;
    int passed = 0;
    int outs_a = 0;
    int outs_b = 0;
    int xfer_a = 0;
    logic stall_mon = 1'b0;
    logic [27:0] exp_a[$];
    logic [27:0] exp_b[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    endfunction

    always @(negedge clk) begin
        if (!reset && bus_a.m_valid && bus_a.m_ready) begin
            outs_a++;
            if (exp_a.size() == 0) begin
                checks++;
                $display("FAIL out_a: unexpected result %0d, expected none", bus_a.m_data);
            end else check("out_a", 32'(bus_a.m_data), 32'(exp_a.pop_front()));
        end
        if (!reset && bus_b.m_valid && bus_b.m_ready) begin
            outs_b++;
            if (exp_b.size() == 0) begin
                checks++;
                $display("FAIL out_b: unexpected result %0d, expected none", bus_b.m_data);
            end else check("out_b", 32'(bus_b.m_data), 32'(exp_b.pop_front()));
        end
        if (!reset && bus_a.s_valid && bus_a.s_ready) xfer_a++;
        if (stall_mon) begin
            check("stall_data",  32'(bus_a.m_data), 32'd40);
            check("stall_valid", 32'(bus_a.m_valid), 32'd1);
            check("stall_vin",   32'(bus_a.mac_valid_in), 32'd0);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input logic [13:0] d);
        int n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        if (sel == 0) begin bus_a.s_data = d; bus_a.s_valid = 1'b1; end
        else          begin bus_b.s_data = d; bus_b.s_valid = 1'b1; end
        while (!rdy && n < 300) begin
            @(negedge clk);
            rdy = (sel == 0) ? bus_a.s_ready : bus_b.s_ready;
            n++;
        end
        if (!rdy) begin
            checks++;
            $display("FAIL send_timeout: s_ready low for %0d cycles, expected high", n);
        end
        tick();
        if (sel == 0) bus_a.s_valid = 1'b0;
        else          bus_b.s_valid = 1'b0;
    endtask

    task automatic load_frame(input int sel, input logic [13:0] taps[4],
                              input logic [13:0] smp[8], input int ns, input int gap);
        for (int i = 0; i < 4; i++) begin
            send(sel, taps[i]);
            repeat (gap) tick();
        end
        for (int i = 0; i < ns; i++) begin
            send(sel, smp[i]);
            repeat (gap) tick();
        end
    endtask

    task automatic wait_outs(input int sel, input int target);
        int n;
        n = 0;
        while (((sel == 0) ? outs_a : outs_b) < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (((sel == 0) ? outs_a : outs_b) < target) begin
            checks++;
            $display("FAIL wait_outs: got %0d results, expected %0d", (sel == 0) ? outs_a : outs_b, target);
        end
        tick();
    endtask

    task automatic push_a(input logic [27:0] v, input int cnt);
        for (int i = 0; i < cnt; i++) exp_a.push_back(v + 28'(10 * i));
    endtask

    logic [13:0] t1[4], t2[4], t5[4];
    logic [13:0] x1[8], x2[8], x5[8], x6[8];

    initial begin
        int n;
        t1 = '{14'd1, 14'd2, 14'd3, 14'd4};
        t2 = '{14'h2000, 14'd1, 14'd0, 14'd0};
        t5 = '{14'd1, 14'd1, 14'd1, 14'd1};
        x1 = '{14'd1, 14'd2, 14'd3, 14'd4, 14'd5, 14'd6, 14'd7, 14'd8};
        x2 = '{14'h2000, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0};
        x5 = '{14'd2, 14'd2, 14'd2, 14'd2, 14'd2, 14'd2, 14'd2, 14'd2};
        x6 = '{14'd4, 14'd3, 14'd2, 14'd1, 14'd0, 14'd0, 14'd0, 14'd0};
        reset = 1'b1;
        bus_a.s_data = '0; bus_a.s_valid = 1'b0; bus_a.m_ready = 1'b1;
        bus_b.s_data = '0; bus_b.s_valid = 1'b0; bus_b.m_ready = 1'b1;
        repeat (2) tick();

        check("rst_s_ready",   32'(bus_a.s_ready), 32'd0);
        check("rst_m_valid",   32'(bus_a.m_valid), 32'd0);
        check("rst_m_data",    32'(bus_a.m_data), 32'd0);
        check("rst_mac_reset", 32'(bus_a.mac_reset), 32'd1);
        check("rst_mac_a",     32'(bus_a.mac_a), 32'd0);
        check("rst_mac_b",     32'(bus_a.mac_b), 32'd0);
        check("rst_vin",       32'(bus_a.mac_valid_in), 32'd0);
        check("rst_state",     32'(st_a), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_s_ready",   32'(bus_a.s_ready), 32'd1);
        check("idle_mac_reset", 32'(bus_a.mac_reset), 32'd0);

        // basic frame: 30,40,50,60,70
        push_a(28'd30, 5);
        load_frame(0, t1, x1, 8, 0);
        wait_outs(0, 5);
        check("t1_state_load_w", 32'(st_a), 32'd0);
        check("t1_s_ready",      32'(bus_a.s_ready), 32'd1);

        // signed extremes: y0 = (-8192)^2 = 2^26, rest zero
        exp_a.push_back(28'h4000000);
        for (int i = 0; i < 4; i++) exp_a.push_back(28'd0);
        load_frame(0, t2, x2, 8, 0);
        wait_outs(0, 10);

        // 20-cycle stall while y1 is presented
        push_a(28'd30, 5);
        load_frame(0, t1, x1, 8, 0);
        wait_outs(0, 11);
        bus_a.m_ready = 1'b0;
        n = 0;
        while (!bus_a.m_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_reached", 32'(bus_a.m_valid), 32'd1);
        tick();
        stall_mon = 1'b1;
        repeat (20) tick();
        stall_mon = 1'b0;
        bus_a.m_ready = 1'b1;
        wait_outs(0, 15);

        // gapped load, then stray s_valid while computing
        xfer_a = 0;
        push_a(28'd30, 5);
        load_frame(0, t1, x1, 8, 1);
        bus_a.s_data = 14'h1555;
        bus_a.s_valid = 1'b1;
        repeat (8) tick();
        bus_a.s_valid = 1'b0;
        wait_outs(0, 20);
        check("t4_transfers", 32'(xfer_a), 32'd12);

        // reset on the second ISSUE cycle of y2
        push_a(28'd30, 2);
        load_frame(0, t1, x1, 8, 0);
        wait_outs(0, 22);
        n = 0;
        while (st_a != 3'd3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_issue_seen", 32'(st_a), 32'd3);
        tick();
        reset = 1'b1;
        tick();
        check("t5_state",     32'(st_a), 32'd0);
        check("t5_m_valid",   32'(bus_a.m_valid), 32'd0);
        check("t5_mac_reset", 32'(bus_a.mac_reset), 32'd1);
        check("t5_vin",       32'(bus_a.mac_valid_in), 32'd0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) exp_a.push_back(28'd8);
        load_frame(0, t5, x5, 8, 0);
        wait_outs(0, 27);

        // M == N: one result per frame, two frames back to back
        exp_b.push_back(28'd20);
        exp_b.push_back(28'd20);
        load_frame(1, t1, x6, 4, 0);
        load_frame(1, t1, x6, 4, 0);
        wait_outs(1, 2);
        check("t6_state_load_w", 32'(st_b), 32'd0);

        check("queue_a_drained", 32'(exp_a.size()), 32'd0);
        check("queue_b_drained", 32'(exp_b.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
